// File: rtl/fetch_redirect_if.sv
// Instruction-memory read port between the fetch stage (master) and imem (slave).
// Data for an enabled read appears on imem_rdata one cycle after imem_en.
interface fetch_redirect_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 64
);
  logic              imem_en;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;

  modport master (output imem_en, output imem_addr, input imem_rdata);
  modport slave  (input imem_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_redirect.sv
// PC generator and fetch stage: one bundle fetch per cycle, redirect squash,
// and a hold register that keeps the output bundle stable across decode stalls.
module fetch_redirect #(
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] PC_INC   = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall,
  input  logic              npc_enn,
  input  logic [PC_W-1:0]   npc_target,
  fetch_redirect_if.master  imem,
  output logic              if_valid,
  output logic [PC_W-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic [31:0]       redir_cnt,
  output logic [31:0]       fetch_cnt
);

  logic [PC_W-1:0]   pc_reg;
  logic [PC_W-1:0]   req_pc_reg;
  logic              req_valid_reg;
  logic              hold_valid_reg;
  logic [INST_W-1:0] hold_inst_reg;
  logic [31:0]       redir_cnt_reg;
  logic [31:0]       fetch_cnt_reg;
  logic              fetch_fire;

  // Redirect must gate the fetch within the same cycle, so this stays a single gate.
  assign fetch_fire     = rstn & ~stall & ~npc_enn;
  assign imem.imem_en   = fetch_fire;
  assign imem.imem_addr = pc_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_reg         <= RESET_PC;
      req_pc_reg     <= '0;
      req_valid_reg  <= 1'b0;
      hold_valid_reg <= 1'b0;
      redir_cnt_reg  <= '0;
      fetch_cnt_reg  <= '0;
    end else if (npc_enn) begin
      pc_reg         <= npc_target;
      req_valid_reg  <= 1'b0;
      hold_valid_reg <= 1'b0;
      if (redir_cnt_reg != '1) begin
        redir_cnt_reg <= redir_cnt_reg + 32'd1;
      end
    end else if (stall) begin
      hold_valid_reg <= 1'b1;
    end else begin
      pc_reg         <= pc_reg + PC_INC;
      req_pc_reg     <= pc_reg;
      req_valid_reg  <= 1'b1;
      hold_valid_reg <= 1'b0;
      if (fetch_cnt_reg != '1) begin
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      end
    end
  end

  // Capture the bundle on the first stalled edge only; imem data is not held by memory.
  always_ff @(posedge clk) begin
    if (stall && !npc_enn && !hold_valid_reg) begin
      hold_inst_reg <= imem.imem_rdata;
    end
  end

  assign if_valid  = req_valid_reg;
  assign if_pc     = req_pc_reg;
  assign if_inst   = hold_valid_reg ? hold_inst_reg : imem.imem_rdata;
  assign redir_cnt = redir_cnt_reg;
  assign fetch_cnt = fetch_cnt_reg;

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench for fetch_redirect: a predictive model pushes expected bundles on
// each issued fetch and pops them as decode consumes the output.
module tb_fetch_redirect;

  localparam int PC_W   = 32;
  localparam int INST_W = 64;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } exp_t;

  logic              clk;
  logic              rstn;
  logic              stall;
  logic              npc_enn;
  logic [PC_W-1:0]   npc_target;
  logic              if_valid;
  logic [PC_W-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  logic [31:0]       redir_cnt;
  logic [31:0]       fetch_cnt;

  fetch_redirect_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

  fetch_redirect #(.PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .stall      (stall),
    .npc_enn    (npc_enn),
    .npc_target (npc_target),
    .imem       (bus),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .redir_cnt  (redir_cnt),
    .fetch_cnt  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [INST_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return {32'b0, a} * 64'd3;
  endfunction

  // Memory returns garbage when not enabled so a missing hold register shows up.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem_word(bus.imem_addr);
    else             bus.imem_rdata <= {$urandom, $urandom};
  end

  int              pass_cnt  = 0;
  int              total_cnt = 0;
  exp_t            exp_q[$];
  logic [PC_W-1:0] model_pc;
  logic [31:0]     redir_exp;
  logic [31:0]     fetch_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    if (exp_q.size() > 0) begin
      check("if_valid", 64'(if_valid), 64'd1);
      check("if_pc", 64'(if_pc), 64'(exp_q[0].pc));
      check("if_inst", if_inst, exp_q[0].inst);
    end else begin
      check("if_valid_bubble", 64'(if_valid), 64'd0);
    end
    check("redir_cnt", 64'(redir_cnt), 64'(redir_exp));
    check("fetch_cnt", 64'(fetch_cnt), 64'(fetch_exp));
  endtask

  // One clock cycle: check outputs, drive inputs, check fetch port, advance model.
  task automatic cycle(input logic st, input logic nj, input logic [PC_W-1:0] tgt);
    exp_t e;
    check_outputs();
    stall      = st;
    npc_enn    = nj;
    npc_target = tgt;
    #1;
    check("imem_en", 64'(bus.imem_en), 64'(!st && !nj));
    if (!st && !nj) check("imem_addr", 64'(bus.imem_addr), 64'(model_pc));
    $display("cycle stall=%0b npc_enn=%0b tgt=%h | if_valid=%0b if_pc=%h if_inst=%h redir=%0d fetch=%0d",
             st, nj, tgt, if_valid, if_pc, if_inst, redir_cnt, fetch_cnt);
    if (nj) begin
      exp_q.delete();
      model_pc = tgt;
      if (redir_exp != 32'hFFFF_FFFF) redir_exp++;
    end else if (!st) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      e.pc   = model_pc;
      e.inst = mem_word(model_pc);
      exp_q.push_back(e);
      model_pc = model_pc + 1;
      if (fetch_exp != 32'hFFFF_FFFF) fetch_exp++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_pc  = '0;
    redir_exp = '0;
    fetch_exp = '0;
  endtask

  initial begin
    rstn       = 1'b0;
    stall      = 1'b0;
    npc_enn    = 1'b0;
    npc_target = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_imem_en", 64'(bus.imem_en), 64'd0);
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_if_pc", 64'(if_pc), 64'd0);
    check("rst_redir_cnt", 64'(redir_cnt), 64'd0);
    check("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
    rstn = 1'b1;

    // T1/T2: sequential fetch up to if_pc=5, stall three cycles, resume
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, '0);

    // T3: redirect while if_pc=7
    for (int i = 0; i < 20 && !(exp_q.size() > 0 && exp_q[0].pc == 7); i++)
      cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 32'h40);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);

    // T4: redirect during a stall drops the held bundle
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h10);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);

    // Stall directly after a redirect: bubble held, then target fetched
    cycle(1'b0, 1'b1, 32'h50);
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);

    // T5: back-to-back redirects
    cycle(1'b0, 1'b1, 32'h20);
    cycle(1'b0, 1'b1, 32'h30);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);

    // T6: PC wrap
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0);

    // T6: fetch counter saturation from a preloaded value
    force dut.fetch_cnt_reg = 32'hFFFF_FFFE;
    #1;
    release dut.fetch_cnt_reg;
    fetch_exp = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0);

    // Asynchronous reset mid-operation
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_imem_en", 64'(bus.imem_en), 64'd0);
    check("mid_rst_imem_addr", 64'(bus.imem_addr), 64'd0);
    check("mid_rst_if_valid", 64'(if_valid), 64'd0);
    check("mid_rst_if_pc", 64'(if_pc), 64'd0);
    check("mid_rst_redir_cnt", 64'(redir_cnt), 64'd0);
    check("mid_rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    stall   = 1'b0;
    npc_enn = 1'b0;
    rstn    = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0);
    check_outputs();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
